// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the two-requester round-robin arbiter: lock-state encoding and requester indices.
// Optional packet locking is enabled with MUX2_ARB_LOCK_EN.
package mux2_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOCK0 = ST_LOCK0,
    LOCK1 = ST_LOCK1
  } lock_st_t;

  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and its single consumer.
// The last-beat signals exist only when MUX2_ARB_LOCK_EN is defined.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] i0_data;
  logic             i0_valid;
  logic             i0_ready;
  logic [WIDTH-1:0] i1_data;
  logic             i1_valid;
  logic             i1_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_ready;
  logic             s0;
`ifdef MUX2_ARB_LOCK_EN
  logic             i0_last;
  logic             i1_last;
  logic             y_last;
`endif

  // master = the environment (requesters plus consumer); slave = the arbiter
  modport master (
    output i0_data, i0_valid, i1_data, i1_valid, y_ready,
`ifdef MUX2_ARB_LOCK_EN
    output i0_last, i1_last,
    input  y_last,
`endif
    input  i0_ready, i1_ready, y_data, y_valid, s0
  );

  modport slave (
    input  i0_data, i0_valid, i1_data, i1_valid, y_ready,
`ifdef MUX2_ARB_LOCK_EN
    input  i0_last, i1_last,
    output y_last,
`endif
    output i0_ready, i1_ready, y_data, y_valid, s0
  );

endinterface

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// Parameterised WIDTH-bit 2:1 select used on the arbiter data path.
// Purely combinational.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  assign y = s0 ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter with a single registered output stage; 1-cycle latency, refills while draining.
// Define MUX2_ARB_LOCK_EN to hold the grant across multi-beat packets (IDLE/LOCK0/LOCK1 FSM).
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  logic [WIDTH-1:0] r_y_data;
  logic             r_y_valid;
  logic             r_s0;
  logic             r_ptr;
`ifdef MUX2_ARB_LOCK_EN
  logic             r_y_last;
  lock_st_t         r_state;
  logic             w_last;
`endif

  logic             w_load;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any;
  logic             w_sel;
  logic [WIDTH-1:0] w_mux_data;

  assign w_load = ~r_y_valid | bus.y_ready;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
`ifdef MUX2_ARB_LOCK_EN
    // a locked packet owns the output even while its requester stalls
    case (r_state)
      LOCK0:   w_gnt0 = bus.i0_valid;
      LOCK1:   w_gnt1 = bus.i1_valid;
      default: begin
        if (bus.i0_valid && bus.i1_valid) begin
          w_gnt0 = (r_ptr == REQ0);
          w_gnt1 = (r_ptr == REQ1);
        end else begin
          w_gnt0 = bus.i0_valid;
          w_gnt1 = bus.i1_valid;
        end
      end
    endcase
`else
    if (bus.i0_valid && bus.i1_valid) begin
      w_gnt0 = (r_ptr == REQ0);
      w_gnt1 = (r_ptr == REQ1);
    end else begin
      w_gnt0 = bus.i0_valid;
      w_gnt1 = bus.i1_valid;
    end
`endif
  end

  assign w_any = w_gnt0 | w_gnt1;
  assign w_sel = w_gnt1 ? REQ1 : REQ0;

  assign bus.i0_ready = rst_n & w_load & w_gnt0;
  assign bus.i1_ready = rst_n & w_load & w_gnt1;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .i0 (bus.i0_data),
    .i1 (bus.i1_data),
    .s0 (w_sel),
    .y  (w_mux_data)
  );

`ifdef MUX2_ARB_LOCK_EN
  assign w_last     = w_sel ? bus.i1_last : bus.i0_last;
  assign bus.y_last = r_y_last;
`endif

  assign bus.y_data  = r_y_data;
  assign bus.y_valid = r_y_valid;
  assign bus.s0      = r_s0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_data  <= '0;
      r_y_valid <= 1'b0;
      r_s0      <= 1'b0;
      r_ptr     <= FIRST_PRIO;
`ifdef MUX2_ARB_LOCK_EN
      r_y_last  <= 1'b0;
      r_state   <= IDLE;
`endif
    end else if (w_load) begin
      if (w_any) begin
        r_y_data  <= w_mux_data;
        r_y_valid <= 1'b1;
        r_s0      <= w_sel;
`ifdef MUX2_ARB_LOCK_EN
        r_y_last  <= w_last;
        // pointer only advances once a whole packet has gone through
        if (w_last) begin
          r_ptr   <= other_req(w_sel);
          r_state <= IDLE;
        end else begin
          r_state <= (w_sel == REQ1) ? LOCK1 : LOCK0;
        end
`else
        r_ptr     <= other_req(w_sel);
`endif
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomised + directed bench for mux2_rr_arbiter with a queue scoreboard and a rule-level reference model.
// Builds with or without MUX2_ARB_LOCK_EN.
module tb_mux2_rr_arbiter;

  localparam int W  = 8;
  localparam bit FP = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux2_rr_arbiter #(.WIDTH(W), .FIRST_PRIO(FP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         idx;
    logic         last;
  } beat_t;

  beat_t sb_q[$];
  int    tests = 0;
  int    fails = 0;

  // reference model state: output occupancy, favoured requester, owner of an open packet (-1 none)
  bit    m_yv;
  bit    m_ptr;
  int    m_lock;
  bit    acc0, acc1;
  bit    m_load, m_g0, m_g1, m_v0, m_v1, m_last;
  beat_t m_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // predictor: decides who should be accepted this cycle and queues the resulting output beat
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_i0_ready", {31'd0, bus.i0_ready}, 32'd0);
      chk("rst_i1_ready", {31'd0, bus.i1_ready}, 32'd0);
      m_yv   = 1'b0;
      m_ptr  = FP;
      m_lock = -1;
      acc0   = 1'b0;
      acc1   = 1'b0;
      sb_q.delete();
    end else begin
      chk("y_valid", {31'd0, bus.y_valid}, {31'd0, m_yv});
      m_v0   = bus.i0_valid;
      m_v1   = bus.i1_valid;
      m_load = !m_yv || bus.y_ready;
      m_g0   = 1'b0;
      m_g1   = 1'b0;
      if (m_lock == 0)        m_g0 = m_v0;
      else if (m_lock == 1)   m_g1 = m_v1;
      else if (m_v0 && m_v1)  begin m_g0 = (m_ptr == 1'b0); m_g1 = (m_ptr == 1'b1); end
      else                    begin m_g0 = m_v0; m_g1 = m_v1; end
      m_g0 = m_g0 && m_load;
      m_g1 = m_g1 && m_load;
      chk("i0_ready", {31'd0, bus.i0_ready}, {31'd0, m_g0});
      chk("i1_ready", {31'd0, bus.i1_ready}, {31'd0, m_g1});
      acc0 = m_g0;
      acc1 = m_g1;
      if (m_g0 || m_g1) begin
        m_b.idx  = m_g1;
        m_b.data = m_g1 ? bus.i1_data : bus.i0_data;
`ifdef MUX2_ARB_LOCK_EN
        m_last = m_g1 ? bus.i1_last : bus.i0_last;
`else
        m_last = 1'b1;
`endif
        m_b.last = m_last;
        sb_q.push_back(m_b);
        m_yv = 1'b1;
        if (m_last) begin
          m_ptr  = !m_b.idx;
          m_lock = -1;
        end else begin
          m_lock = m_b.idx ? 1 : 0;
        end
      end else if (m_load) begin
        m_yv = 1'b0;
      end
    end
  end

  // monitor: every beat the consumer takes must be the next one predicted
  always @(negedge clk) begin
    if (rst_n && bus.y_valid && bus.y_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got y_data %0h s0 %0d, expected no beat", bus.y_data, bus.s0);
      end else begin
        m_b = sb_q.pop_front();
        chk("y_data", {24'd0, bus.y_data}, {24'd0, m_b.data});
        chk("s0", {31'd0, bus.s0}, {31'd0, m_b.idx});
`ifdef MUX2_ARB_LOCK_EN
        chk("y_last", {31'd0, bus.y_last}, {31'd0, m_b.last});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i0_data  = 8'hA0;
    bus.i1_data  = 8'hB1;
    bus.i0_valid = 1'b1;
    bus.i1_valid = 1'b1;
    bus.y_ready  = 1'b1;
`ifdef MUX2_ARB_LOCK_EN
    bus.i0_last  = 1'b1;
    bus.i1_last  = 1'b1;
`endif
    rst_n = 1'b0;

    // reset held with both requesters valid
    step();
    step();
    chk("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    chk("rst_y_data", {24'd0, bus.y_data}, 32'd0);
    chk("rst_s0", {31'd0, bus.s0}, 32'd0);

    // contention: alternation from FIRST_PRIO
    rst_n = 1'b1;
    step();
    chk("first_grant_s0", {31'd0, bus.s0}, {31'd0, FP});
    chk("first_grant_data", {24'd0, bus.y_data}, 32'h0000_00A0);
    repeat (5) step();

    // single requester, then contention again
    bus.i0_valid = 1'b0;
    bus.i1_data  = 8'h3C;
    repeat (3) step();
    chk("single_s0", {31'd0, bus.s0}, 32'd1);
    chk("single_data", {24'd0, bus.y_data}, 32'h0000_003C);
    bus.i0_valid = 1'b1;
    step();
    chk("after_single_s0", {31'd0, bus.s0}, 32'd0);

    // backpressure then release
    bus.y_ready = 1'b0;
    repeat (4) step();
    bus.y_ready = 1'b1;
    repeat (6) step();

    // mid-operation reset with the pointer pointing away from FIRST_PRIO
    bus.i0_valid = 1'b0;
    bus.i1_valid = 1'b0;
    step();
    bus.i0_valid = 1'b1;
    bus.y_ready  = 1'b0;
    step();
    bus.i0_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_y_valid", {31'd0, bus.y_valid}, 32'd0);
    rst_n = 1'b1;
    bus.i0_valid = 1'b1;
    bus.i1_valid = 1'b1;
    bus.y_ready  = 1'b1;
    step();
    chk("midrst_ptr", {31'd0, bus.s0}, {31'd0, FP});

`ifdef MUX2_ARB_LOCK_EN
    // 3-beat packet from i0 with i1 waiting throughout
    bus.i0_valid = 1'b0;
    bus.i1_valid = 1'b0;
    step();
    bus.i1_valid = 1'b1;
    bus.i1_data  = 8'hB1;
    bus.i1_last  = 1'b1;
    begin
      int k;
      int guard;
      k = 0;
      guard = 0;
      while (k < 3 && guard < 20) begin
        bus.i0_valid = 1'b1;
        bus.i0_data  = 8'h10 + 8'(k);
        bus.i0_last  = (k == 2);
        step();
        if (acc0) k++;
        guard++;
      end
      chk("lock_beats_sent", k, 3);
    end
    bus.i0_valid = 1'b0;
    bus.i0_last  = 1'b1;
    repeat (3) step();
`endif

    // randomised traffic obeying the hold-while-stalled rule
    bus.i0_valid = 1'b0;
    bus.i1_valid = 1'b0;
    step();
    for (int c = 0; c < 400; c++) begin
      if (!bus.i0_valid || acc0) begin
        bus.i0_valid = ($urandom_range(0, 2) != 0);
        bus.i0_data  = 8'($urandom);
`ifdef MUX2_ARB_LOCK_EN
        bus.i0_last  = ($urandom_range(0, 2) == 0);
`endif
      end
      if (!bus.i1_valid || acc1) begin
        bus.i1_valid = ($urandom_range(0, 2) != 0);
        bus.i1_data  = 8'($urandom);
`ifdef MUX2_ARB_LOCK_EN
        bus.i1_last  = ($urandom_range(0, 2) == 0);
`endif
      end
      bus.y_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // drain: every predicted beat must have been consumed
    bus.i0_valid = 1'b0;
    bus.i1_valid = 1'b0;
    bus.y_ready  = 1'b1;
    repeat (3) step();
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one WIDTH-bit output path between two valid/ready requesters (i0, i1) through a 2:1 select.
- Round-robin arbitration drives the select s0; the selected beat is captured in a single output register.
- Sits in front of any single-consumer resource that two producers contend for.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- FIRST_PRIO, 0, requester favoured on the first contended cycle after reset (0 = i0, 1 = i1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- i0_data  in  WIDTH  requester 0 payload.
- i0_valid  in  1  requester 0 has a beat.
- i0_ready  out  1  requester 0 beat accepted this cycle.
- i1_data  in  WIDTH  requester 1 payload.
- i1_valid  in  1  requester 1 has a beat.
- i1_ready  out  1  requester 1 beat accepted this cycle.
- y_data  out  WIDTH  registered output payload.
- y_valid  out  1  output beat present.
- y_ready  in  1  consumer accepts the output beat.
- s0  out  1  registered select of the last accepted beat (0 = i0, 1 = i1).

Behaviour:
- Reset (rst_n = 0 at posedge):
  - y_valid = 0, y_data = 0, s0 = 0.
  - Priority pointer = FIRST_PRIO; lock state = IDLE.
  - Reset wins over any simultaneous handshake; a beat in flight is dropped.
  - i*_ready are combinational and are 0 while rst_n = 0.
- Load enable: load = ~y_valid | y_ready. The output register may refill in the same cycle it drains.
- Grant (combinational, only when load = 1):
  - Only one requester valid: grant it.
  - Both valid: grant the requester the pointer favours.
  - Neither valid: no grant.
- i0_ready = load & grant0; i1_ready = load & grant1. The two readies are never both 1.
- On an accepted beat:
  - y_data ← granted data; y_valid ← 1; s0 ← granted index.
  - Pointer ← the other index. The pointer flips only on accepted beats, never on idle cycles.
- On load with no grant: y_valid ← 0.
- While y_valid = 1 and y_ready = 0: y_data, y_valid and s0 hold; both readies = 0.
- Latency: 1 cycle from acceptance to y_valid. Throughput: 1 beat/cycle with y_ready held high.
- Fairness: under continuous contention, grants alternate 0,1,0,1… (starting from FIRST_PRIO). Neither requester waits more than one accepted beat.
- Requesters must hold data stable while valid and not ready; the block does not check this.

Optional Feature:
- Macro: MUX2_ARB_LOCK_EN.
- Defined:
  - Adds ports i0_last, i1_last (in, 1) and y_last (out, 1, reset 0, registered alongside y_data).
  - FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: an accepted beat with last = 0 moves to LOCKn for the granted requester n.
  - LOCKn: only requester n may be granted, even if it deasserts valid; the other requester's ready = 0.
  - LOCKn: an accepted beat from n with last = 1 returns to IDLE and flips the pointer.
  - The pointer flips only on the last beat of a packet. A single-beat packet (last = 1) in IDLE stays in IDLE.
- Undefined: no last ports and no FSM; arbitration is per beat as above.

Decomposition:
- Package mux2_arb_pkg holds:
  - State encoding localparams ST_IDLE = 2'd0, ST_LOCK0 = 2'd1, ST_LOCK1 = 2'd2.
  - Requester index constants REQ0 = 1'b0, REQ1 = 1'b1.
- Natural sub-module: mux2_w, a parameterised WIDTH-bit 2:1 select (inputs i0, i1, select s0, output y) for the data path.
- Arbitration, FSM and output register stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 with i0_valid = i1_valid = 1 for 2 cycles → y_valid = 0, y_data = 0, s0 = 0, both readies 0; release → first grant goes to i0 (FIRST_PRIO = 0).
- Contention: i0_data = 8'hA0, i1_data = 8'hB1, both valid, y_ready = 1 for 6 cycles → y_data sequence A0, B1, A0, B1, A0, B1 and s0 sequence 0, 1, 0, 1, 0, 1, one cycle after each accept.
- Single requester: only i1_valid with 8'h3C for 3 cycles → i1_ready = 1 each cycle, y_data = 3C, s0 = 1; then raise i0 as well → next grant goes to i0.
- Backpressure: y_ready = 0 for 4 cycles with both valid → y_data/s0 frozen after the first load, both readies 0, pointer unchanged; y_ready = 1 → alternation resumes with no beat lost or duplicated.
- Mid-operation reset: assert rst_n = 0 while y_valid = 1 and y_ready = 0 → next cycle y_valid = 0 and pointer = FIRST_PRIO.
- MUX2_ARB_LOCK_EN: i0 sends 3 beats (last = 0, 0, 1) while i1 is valid throughout → y carries the three i0 beats contiguously, i1_ready = 0 throughout, then i1 is granted next and y_last = 1 only on the third i0 beat.
